mc_ctrl: RTL

- Multi-cycle main controller for the MIPS datapath. It sequences PC, IR, the register file, ALU, data memory and the immediate extender (drives ext_op) through FETCH/DECODE/EXE/MEM/WB.
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, nop.
- Replaces the single-cycle combinational controller; it also counts retired instructions.

---
 rtl/mc_defs.sv | 62 ++++++
 rtl/mc_ctrl_if.sv | 39 +++
 rtl/mc_decode.sv | 81 ++++++++
 rtl/mc_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mc_defs.sv
// Shared encodings for the multi-cycle MIPS main controller: FSM states,
// opcode/funct values, instruction classes and datapath select codes.
package mc_defs;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU,
        C_SUBU,
        C_JR,
        C_NOP,
        C_ORI,
        C_LW,
        C_SW,
        C_BEQ,
        C_LUI,
        C_J,
        C_JAL,
        C_ILL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_REG  = 2'b11;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_RA   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MDR   = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath control bundle. The controller (master) reads the
// IR and ALU zero flag and drives every enable, select and status signal.
interface mc_ctrl_if
    import mc_defs::*;
#(
    parameter int CNT_W = 32
) ();

    // No handshake: enables are single-cycle strobes that take effect on the
    // next rising clock edge; selects only matter while their enable is high.
    logic [31:0]      instr;
    logic             zero;
    logic             pc_we;
    logic             ir_we;
    logic [1:0]       npc_sel;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [1:0]       ext_op;
    logic             mem_we;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    state_t           state;

    modport master (
        input  instr, zero,
        output pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, alu_op, ext_op, mem_we, retire, retired_cnt, state
    );

    modport slave (
        output instr, zero,
        input  pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, alu_op, ext_op, mem_we, retire, retired_cnt, state
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier plus the state-independent datapath
// controls (immediate extension, ALU operation and ALU B-operand select).
module mc_decode
    import mc_defs::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output logic [1:0]   ext_op,
    output logic [1:0]   alu_op,
    output logic         alu_src
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    always_comb begin
        cls = C_ILL;
        case (op)
            OP_RTYPE: begin
                // Only the all-zero word is nop; other funct=0 encodings are unknown.
                if (instr == 32'h0) begin
                    cls = C_NOP;
                end else begin
                    case (funct)
                        FN_ADDU: cls = C_ADDU;
                        FN_SUBU: cls = C_SUBU;
                        FN_JR:   cls = C_JR;
                        default: cls = C_ILL;
                    endcase
                end
            end
            OP_ORI:  cls = C_ORI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_LUI:  cls = C_LUI;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILL;
        endcase
    end

    always_comb begin
        ext_op  = EXT_ZERO;
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        case (cls)
            C_ADDU: alu_op = ALU_ADD;
            C_SUBU: alu_op = ALU_SUB;
            C_ORI: begin
                ext_op  = EXT_ZERO;
                alu_op  = ALU_OR;
                alu_src = 1'b1;
            end
            C_LW, C_SW: begin
                ext_op  = EXT_SIGN;
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
            end
            C_BEQ: begin
                ext_op  = EXT_SIGN;
                alu_op  = ALU_SUB;
            end
            // lui is $0 | (imm<<16): the extender does the shift, the ALU ORs with zero.
            C_LUI: begin
                ext_op  = EXT_LUI;
                alu_op  = ALU_OR;
                alu_src = 1'b1;
            end
            default: begin
                ext_op  = EXT_ZERO;
                alu_op  = ALU_ADD;
                alu_src = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXE/MEM/WB sequencer, write
// enables and next-PC/writeback selects, plus a retired-instruction counter.
module mc_ctrl
    import mc_defs::*;
#(
    parameter int CNT_W          = 32,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    instr_class_t     cls;

    logic       pc_we_w;
    logic       ir_we_w;
    logic       reg_we_w;
    logic       mem_we_w;
    logic       retire_w;
    logic [1:0] npc_sel_w;
    logic [1:0] reg_dst_w;
    logic [1:0] wd_sel_w;

    mc_decode u_decode (
        .instr   (bus.instr),
        .cls     (cls),
        .ext_op  (bus.ext_op),
        .alu_op  (bus.alu_op),
        .alu_src (bus.alu_src)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            if (retire_w) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    case (cls)
                        C_J, C_JAL, C_JR, C_NOP: state_q <= S_FETCH;
                        C_ILL: state_q <= ILLEGAL_AS_NOP ? S_FETCH : S_DECODE;
                        default: state_q <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    case (cls)
                        C_BEQ:      state_q <= S_FETCH;
                        C_LW, C_SW: state_q <= S_MEM;
                        default:    state_q <= S_WB;
                    endcase
                end
                S_MEM:   state_q <= (cls == C_LW) ? S_WB : S_FETCH;
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Enables are gated by reset here so the edge that applies reset never writes.
    always_comb begin
        pc_we_w   = 1'b0;
        ir_we_w   = 1'b0;
        reg_we_w  = 1'b0;
        mem_we_w  = 1'b0;
        retire_w  = 1'b0;
        npc_sel_w = NPC_PC4;
        reg_dst_w = DST_RT;
        wd_sel_w  = WD_ALU;
        case (state_q)
            S_FETCH: begin
                ir_we_w = 1'b1;
                pc_we_w = 1'b1;
            end
            S_DECODE: begin
                case (cls)
                    C_J: begin
                        pc_we_w   = 1'b1;
                        npc_sel_w = NPC_JMP;
                        retire_w  = 1'b1;
                    end
                    // The PC register already holds PC+4, which is the link value.
                    C_JAL: begin
                        pc_we_w   = 1'b1;
                        npc_sel_w = NPC_JMP;
                        reg_we_w  = 1'b1;
                        reg_dst_w = DST_RA;
                        wd_sel_w  = WD_PC;
                        retire_w  = 1'b1;
                    end
                    C_JR: begin
                        pc_we_w   = 1'b1;
                        npc_sel_w = NPC_REG;
                        retire_w  = 1'b1;
                    end
                    C_NOP: retire_w = 1'b1;
                    C_ILL: retire_w = ILLEGAL_AS_NOP;
                    default: ;
                endcase
            end
            S_EXE: begin
                if (cls == C_BEQ) begin
                    pc_we_w   = bus.zero;
                    npc_sel_w = NPC_BR;
                    retire_w  = 1'b1;
                end
            end
            S_MEM: begin
                if (cls == C_SW) begin
                    mem_we_w = 1'b1;
                    retire_w = 1'b1;
                end
            end
            S_WB: begin
                reg_we_w = 1'b1;
                retire_w = 1'b1;
                case (cls)
                    C_ADDU, C_SUBU: reg_dst_w = DST_RD;
                    C_LW:           wd_sel_w  = WD_MDR;
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (reset) begin
            pc_we_w  = 1'b0;
            ir_we_w  = 1'b0;
            reg_we_w = 1'b0;
            mem_we_w = 1'b0;
            retire_w = 1'b0;
        end
    end

    assign bus.pc_we       = pc_we_w;
    assign bus.ir_we       = ir_we_w;
    assign bus.reg_we      = reg_we_w;
    assign bus.mem_we      = mem_we_w;
    assign bus.retire      = retire_w;
    assign bus.npc_sel     = npc_sel_w;
    assign bus.reg_dst     = reg_dst_w;
    assign bus.wd_sel      = wd_sel_w;
    assign bus.retired_cnt = cnt_q;
    assign bus.state       = state_q;

endmodule
